switch_output_arbiter: RTL and testbench
========================================

# switch_output_arbiter

Per-output-port round-robin arbiter for the 4-port switch. One instance sits in front of each egress port of `switch_4port`.
- Each instance sees the head-of-queue packet of all four ingress buffers.
- It selects those whose one-hot target matches its own `PORT_ID` and grants one per transfer, rotating fairly.
- The granted packet goes into a single-entry output register with a valid/ready handshake toward the egress port logic.

## Interface
Parameters:
- `PORT_ID`, 0: index (0-3) of the egress port this instance serves; selects bit `PORT_ID` of each `req_target`.
- `CNT_W`, 16: width of the delivered-packet counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  4  ingress buffer i has a head packet.
- `req_data`  in  4x8  head packet data per ingress i (packed `[3:0][7:0]`).
- `req_source`  in  4x4  one-hot source per ingress i.
- `req_target`  in  4x4  one-hot (or multi-hot) target per ingress i.
- `grant`  out  4  one-hot pop pulse to ingress i; combinational, at most one bit set.
- `out_valid`  out  1  output register holds a packet.
- `out_data`  out  8  registered packet data.
- `out_source`  out  4  registered one-hot source.
- `out_ready`  in  1  egress accepts the packet this cycle.
- `last_grant`  out  2  index of most recently granted ingress.
- `pkt_count`  out  CNT_W  number of packets accepted by egress (`out_valid && out_ready`).

## Operation
- Eligible: `elig[i] = req_valid[i] && req_target[i][PORT_ID]`.
- Load enable: `load = !out_valid || out_ready`. The register accepts new data when empty, or when draining in the same cycle.
- Pick:
  - Pointer `ptr` (2 bits) marks the highest-priority index.
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first eligible index wins.
- `grant[w] = load && |elig`, only for the winning index w. All other bits are 0.
- On a clock edge with a grant:
  - `out_data <= req_data[w]`, `out_source <= req_source[w]`, `out_valid <= 1`.
  - `last_grant <= w`, `ptr <= (w+1) mod 4`.
- On a clock edge with no grant:
  - `ptr` holds.
  - `out_valid <= out_valid && !out_ready`.
  - Data and source registers hold.
- State machine:
  - EMPTY: `out_valid=0`. Goes to FULL on a grant.
  - FULL: `out_valid=1`.
    - `out_ready=1` with a grant: stays FULL, back-to-back.
    - `out_ready=1` with no eligible request: goes to EMPTY.
    - `out_ready=0`: stays FULL; data, source and `grant` (all 0) are stable.
- `pkt_count` increments on every `out_valid && out_ready` edge and wraps from 2^CNT_W-1 to 0.
- Multicast: an ingress packet targeting several ports is granted independently by each arbiter. Pop coordination across arbiters is outside this block.
- Requests not targeting `PORT_ID` are never granted, whatever `ptr` is.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_source=0`, `last_grant=0`, `ptr=0`, `pkt_count=0`. `grant=0` while `rst_n=0`.
- Reset is asynchronous. Asserting it mid-transfer clears the output register immediately; the pending packet is discarded and not counted.
- Latency:
  - A request eligible before edge N, with load true, yields `grant` high during the cycle before edge N.
  - `out_valid=1` with the packet follows edge N.
  - The ingress pops at edge N.
- Throughput: one packet per cycle while `out_ready=1` and requests persist.
- Fairness: with all four ingresses continuously eligible, grants follow 0,1,2,3,0,... from reset. No ingress waits more than 3 grants.
- `grant` depends combinationally on `req_*`, `out_valid` and `out_ready`. Requesters must not feed `grant` back into `req_valid` in the same cycle.

## Structure
- `packet_pkg` gains:
  - `NUM_PORTS=4` and `DATA_W=8`.
  - `port_idx_t` (logic [1:0]).
  - `port_mask_t` (logic [3:0]).
  - A `pkt_t` struct {data, source, target}.
- Sub-module `rr_priority_picker`: purely combinational. Inputs are a 4-bit request mask and a 2-bit pointer; outputs are a one-hot winner and its index plus `any`. It is reusable by other schedulers.
- The top holds the output register, pointer, state and counter.

## Test plan
- Single packet: reset, PORT_ID=1, req 0 with data=AA, src=0001, tgt=0010, `out_ready=1` → `grant=0001` for one cycle; next cycle `out_valid=1`, `out_data=AA`, `out_source=0001`; `pkt_count=1`.
- Filter: PORT_ID=2, all four req_valid with tgt=0001 → `grant` stays 0, `out_valid` stays 0 for 10 cycles.
- Round robin: PORT_ID=3, all four eligible and held with data 10/11/12/13, `out_ready=1` → outputs 10,11,12,13,10 on consecutive cycles; `last_grant` 0,1,2,3,0.
- Backpressure: FULL with data=BB, `out_ready=0` for 5 cycles while req 2 is eligible → `grant=0`, `out_data` stays BB. On `out_ready=1`, `grant=0100` in the same cycle and the next `out_data` is req 2's data.
- Counter wrap: CNT_W=4, 17 accepted packets → `pkt_count=1`.
- Reset mid-operation: `rst_n` low while `out_valid=1` → outputs, `ptr` and `pkt_count` clear asynchronously. After release, the first grant goes to the lowest eligible index from 0.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared packet types and constants for the 4-port switch datapath.
package packet_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 8;

    typedef logic [1:0]        port_idx_t;
    typedef logic [3:0]        port_mask_t;
    typedef logic [DATA_W-1:0] data_t;

    // One packet as seen at the head of an ingress buffer.
    typedef struct packed {
        data_t      data;
        port_mask_t source;
        port_mask_t target;
    } pkt_t;

    // Occupancy of a single-entry output register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request bit found when
// scanning from ptr upward (modulo 4) wins.
module rr_priority_picker
    import packet_pkg::*;
(
    input  port_mask_t req,
    input  port_idx_t  ptr,
    output port_mask_t winner,
    output port_idx_t  win_idx,
    output logic       any
);

    port_idx_t idx;

    // Scan ptr, ptr+1, ptr+2, ptr+3 and keep only the first hit.
    always_comb begin
        winner  = '0;
        win_idx = ptr;
        any     = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr + port_idx_t'(k);
            if (!any && req[idx]) begin
                any         = 1'b1;
                winner[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/switch_output_arbiter.sv
// Per-egress round-robin arbiter with a single-entry valid/ready output register.
module switch_output_arbiter
    import packet_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req_valid,
    input  logic [3:0][7:0]       req_data,
    input  logic [3:0][3:0]       req_source,
    input  logic [3:0][3:0]       req_target,
    output logic [3:0]            grant,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic [3:0]            out_source,
    input  logic                  out_ready,
    output logic [1:0]            last_grant,
    output logic [CNT_W-1:0]      pkt_count
);

    out_state_t       state_reg, state_next;
    port_idx_t        ptr_reg;
    data_t            data_reg;
    port_mask_t       source_reg;
    port_idx_t        last_grant_reg;
    logic [CNT_W-1:0] pkt_count_reg;

    port_mask_t elig;
    port_mask_t winner;
    port_idx_t  win_idx;
    logic       any_elig;
    logic       load;
    logic       grant_fire;

    // A request is eligible only if its target mask includes this egress port.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
            assign elig[gi] = req_valid[gi] && req_target[gi][PORT_ID];
        end
    endgenerate

    rr_priority_picker u_picker (
        .req     (elig),
        .ptr     (ptr_reg),
        .winner  (winner),
        .win_idx (win_idx),
        .any     (any_elig)
    );

    assign out_valid  = (state_reg == ST_FULL);
    assign load       = !out_valid || out_ready;
    // rst_n gates the pop so no ingress is drained while the block is held in reset.
    assign grant_fire = rst_n && load && any_elig;
    assign grant      = grant_fire ? winner : '0;

    assign out_data   = data_reg;
    assign out_source = source_reg;
    assign last_grant = last_grant_reg;
    assign pkt_count  = pkt_count_reg;

    // Output register occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next occupancy: a grant always fills the register; a drain without a refill empties it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (grant_fire) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (grant_fire) begin
                    state_next = ST_FULL;
                end else if (out_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Capture the winning packet and advance the fairness pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg       <= '0;
            source_reg     <= '0;
            last_grant_reg <= '0;
            ptr_reg        <= '0;
        end else if (grant_fire) begin
            data_reg       <= req_data[win_idx];
            source_reg     <= req_source[win_idx];
            last_grant_reg <= win_idx;
            ptr_reg        <= win_idx + 2'd1;
        end
    end

    // Count packets accepted by the egress; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_reg <= '0;
        end else if (out_valid && out_ready) begin
            pkt_count_reg <= pkt_count_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Self-checking bench for switch_output_arbiter (PORT_ID=2, CNT_W=4).
module tb_switch_output_arbiter;

    localparam int PID = 2;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_data;
    logic [3:0][3:0] req_source;
    logic [3:0][3:0] req_target;
    logic [3:0]      grant;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [3:0]      out_source;
    logic            out_ready;
    logic [1:0]      last_grant;
    logic [CW-1:0]   pkt_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         m_ptr;
    bit         m_valid;
    logic [7:0] m_data;
    logic [3:0] m_source;
    logic [1:0] m_last;
    int         m_count;

    always #5 clk = ~clk;

    switch_output_arbiter #(.PORT_ID(PID), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_source (req_source),
        .req_target (req_target),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_source (out_source),
        .out_ready  (out_ready),
        .last_grant (last_grant),
        .pkt_count  (pkt_count)
    );

    wire logic [22:0] dut_vec = {grant, out_valid, out_data, out_source, last_grant, pkt_count};

    // Expected grant: first eligible index scanning from the model pointer.
    function automatic logic [3:0] exp_grant();
        int idx;
        if (!rst_n) return 4'b0;
        if (m_valid && !out_ready) return 4'b0;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (req_valid[idx] && req_target[idx][PID]) return 4'(1) << idx;
        end
        return 4'b0;
    endfunction

    function automatic logic [22:0] model_vec();
        return {exp_grant(), m_valid, m_data, m_source, m_last, 4'(m_count)};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_source = '0; m_last = '0; m_count = 0;
    endtask

    // Advance the model over one rising edge, then settle 1 time unit past it.
    task automatic clock_model();
        logic [3:0] g;
        @(posedge clk);
        g = exp_grant();
        if (m_valid && out_ready) m_count = (m_count + 1) % 16;
        if (g != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    m_data   = req_data[i];
                    m_source = req_source[i];
                    m_last   = 2'(i);
                    m_ptr    = (i + 1) % 4;
                end
            end
            m_valid = 1;
        end else begin
            m_valid = m_valid && !out_ready;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_data = '0; req_source = '0; req_target = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        model_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 8'(8'h50 + i); req_source[i] = 4'(1) << i; req_target[i] = 4'hF;
        end
        @(negedge clk);
        n_vec++;
        if (dut_vec !== 23'h0) begin
            n_bad++;
            $display("FAIL reset_state got %h expected %h", dut_vec, 23'h0);
        end
        clock_model();
        clear_reqs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001; req_data[0] = 8'hAA; req_source[0] = 4'b0001; req_target[0] = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL single_model cyc %0d got %h expected %h", c, dut_vec, model_vec());
            end
            n_vec++;
            case (c)
                0: if (grant !== 4'b0001) begin
                       n_bad++; $display("FAIL single_grant got %b expected 0001", grant);
                   end
                1: if ({out_valid, out_data, out_source} !== {1'b1, 8'hAA, 4'b0001}) begin
                       n_bad++; $display("FAIL single_out got %b/%h/%b expected 1/aa/0001", out_valid, out_data, out_source);
                   end
                default: if (pkt_count !== 4'd1) begin
                       n_bad++; $display("FAIL single_count got %0d expected 1", pkt_count);
                   end
            endcase
            clock_model();
            clear_reqs();
        end
    endtask

    task automatic test_filter();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 8'(i); req_source[i] = 4'(1) << i; req_target[i] = 4'b0001;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if ({grant, out_valid} !== 5'b0 || dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL filter cyc %0d got grant=%b valid=%b expected grant=0000 valid=0", c, grant, out_valid);
            end
            clock_model();
        end
        clear_reqs();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        logic [1:0] exp_l [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 8'(8'h10 + i); req_source[i] = 4'(1) << i; req_target[i] = 4'b0100;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL rr_model cyc %0d got %h expected %h", c, dut_vec, model_vec());
            end
            if (c > 0) begin
                n_vec++;
                if ({out_valid, out_data, last_grant} !== {1'b1, exp_d[c-1], exp_l[c-1]}) begin
                    n_bad++;
                    $display("FAIL rr_seq cyc %0d got data=%h last=%0d expected data=%h last=%0d",
                             c, out_data, last_grant, exp_d[c-1], exp_l[c-1]);
                end
            end
            clock_model();
        end
        clear_reqs();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        req_valid = 4'b0010; req_data[1] = 8'hBB; req_source[1] = 4'b0010; req_target[1] = 4'b0100;
        clock_model();
        clear_reqs();
        out_ready = 1'b0;
        req_valid = 4'b0100; req_data[2] = 8'hCC; req_source[2] = 4'b0100; req_target[2] = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) out_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL bp_model cyc %0d got %h expected %h", c, dut_vec, model_vec());
            end
            n_vec++;
            if (c < 5 && {grant, out_valid, out_data} !== {4'b0000, 1'b1, 8'hBB}) begin
                n_bad++;
                $display("FAIL bp_hold cyc %0d got grant=%b data=%h expected grant=0000 data=bb", c, grant, out_data);
            end else if (c == 5 && grant !== 4'b0100) begin
                n_bad++;
                $display("FAIL bp_release got grant=%b expected 0100", grant);
            end else if (c == 6 && out_data !== 8'hCC) begin
                n_bad++;
                $display("FAIL bp_next got data=%h expected cc", out_data);
            end
            clock_model();
            if (c == 5) clear_reqs();
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001; req_data[0] = 8'h77; req_source[0] = 4'b0001; req_target[0] = 4'b0100;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL wrap_model cyc %0d got %h expected %h", c, dut_vec, model_vec());
            end
            clock_model();
        end
        @(negedge clk);
        n_vec++;
        if (pkt_count !== 4'd1) begin
            n_bad++;
            $display("FAIL wrap_count got %0d expected 1", pkt_count);
        end
    endtask

    task automatic test_reset_mid();
        // Register is full and streaming from the previous scenario.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (dut_vec !== 23'h0) begin
            n_bad++;
            $display("FAIL async_reset got %h expected %h", dut_vec, 23'h0);
        end
        rst_n = 1'b1;
        clear_reqs();
        req_valid = 4'b1010;
        req_data[1] = 8'h31; req_source[1] = 4'b0010; req_target[1] = 4'b0110;
        req_data[3] = 8'h33; req_source[3] = 4'b1000; req_target[3] = 4'b1100;
        @(negedge clk);
        n_vec++;
        if (grant !== 4'b0010 || dut_vec !== model_vec()) begin
            n_bad++;
            $display("FAIL post_reset_grant got %b expected 0010", grant);
        end
        clock_model();
        clear_reqs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                req_valid[i]  = ($urandom_range(0, 99) < 60);
                req_data[i]   = 8'($urandom);
                req_source[i] = 4'(1) << $urandom_range(0, 3);
                req_target[i] = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d got %h expected %h", c, dut_vec, model_vec());
            end
            clock_model();
        end
        clear_reqs();
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        clear_reqs();
        model_reset();
        test_reset();
        test_single();
        test_filter();
        test_round_robin();
        test_backpressure();
        test_counter_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
